muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multu/divu unit with HI/LO registers and ID-stage stall generation.
// Define MULDIV_DIV_EN to include the restoring divider; without it divu is an unrelated instruction.
module muldiv_ctrl #(
   parameter int MUL_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic [31:0] instr,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [4:0] LAST_CNT = 5'(MUL_CYCLES - 1);

`ifdef MULDIV_DIV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3} state_t;
`endif

   state_t      state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] opb_q, opb_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic is_special, is_multu, is_mfhi, is_mthi, is_mflo, is_mtlo, is_related;
   logic is_divu;
   logic unused_instr;

   // Accumulator holds {partial product high, remaining multiplier bits}.
   function automatic logic [63:0] mul_step(input logic [63:0] acc, input logic [31:0] mcand);
      logic [32:0] sum;
      sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
      return {sum, acc[31:1]};
   endfunction

`ifdef MULDIV_DIV_EN
   // Accumulator holds {partial remainder, dividend bits shifting out / quotient bits shifting in}.
   function automatic logic [63:0] div_step(input logic [63:0] acc, input logic [31:0] dvsr);
      logic [32:0] cand;
      logic [32:0] trial;
      cand  = {acc[63:32], acc[31]};
      trial = cand - {1'b0, dvsr};
      if (!trial[32]) begin
         return {trial[31:0], acc[30:0], 1'b1};
      end
      return {cand[31:0], acc[30:0], 1'b0};
   endfunction
`endif

   assign is_special = (instr[31:26] == 6'd0);
   assign is_multu   = is_special && (instr[5:0] == 6'd25);
   assign is_mfhi    = is_special && (instr[5:0] == 6'd16);
   assign is_mthi    = is_special && (instr[5:0] == 6'd17);
   assign is_mflo    = is_special && (instr[5:0] == 6'd18);
   assign is_mtlo    = is_special && (instr[5:0] == 6'd19);
`ifdef MULDIV_DIV_EN
   assign is_divu    = is_special && (instr[5:0] == 6'd27);
`else
   assign is_divu    = 1'b0;
`endif
   assign is_related   = is_multu | is_divu | is_mfhi | is_mthi | is_mflo | is_mtlo;
   assign unused_instr = ^instr[25:6];

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid) begin
               if (is_multu) begin
                  acc_d   = {32'd0, rt_val};
                  opb_d   = rs_val;
                  count_d = 5'd0;
                  busy_d  = 1'b1;
                  state_d = MUL;
`ifdef MULDIV_DIV_EN
               end else if (is_divu) begin
                  acc_d   = {32'd0, rs_val};
                  opb_d   = rt_val;
                  count_d = 5'd0;
                  busy_d  = 1'b1;
                  state_d = DIV;
`endif
               end else if (is_mthi) begin
                  hi_d = rs_val;
               end else if (is_mtlo) begin
                  lo_d = rs_val;
               end
            end
         end
         MUL: begin
            acc_d   = mul_step(acc_q, opb_q);
            count_d = count_q + 5'd1;
            if (count_q == LAST_CNT) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
`ifdef MULDIV_DIV_EN
         DIV: begin
            acc_d   = div_step(acc_q, opb_q);
            count_d = count_q + 5'd1;
            if (count_q == LAST_CNT) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
`endif
         DONE: begin
            hi_d    = acc_q[63:32];
            lo_d    = acc_q[31:0];
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= 5'd0;
         acc_q   <= 64'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
      opb_q <= opb_d;
   end

   assign stall = valid && (state_q != IDLE) && is_related;
   assign busy  = busy_q;
   assign done  = done_q;
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule
